// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage:
// bus layouts, widths, lsu_op bits, stall bits, FSM states.
package mem_stage_pkg;

    localparam int EX2MEM_WD = 113;
    localparam int MEM2WB_WD = 102;
    localparam int MEM2EX_WD = 38;
    localparam int WB2EX_WD  = 38;

    localparam int LSU_LB  = 0;
    localparam int LSU_LBU = 1;
    localparam int LSU_LH  = 2;
    localparam int LSU_LHU = 3;
    localparam int LSU_LW  = 4;
    localparam int LSU_SW  = 5;

    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [5:0]  lsu_op;
        logic [3:0]  data_ram_sel;
        logic        sel_load;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
        logic [31:0] pc;
        logic [31:0] inst;
    } ex2mem_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic [31:0] pc;
        logic [31:0] inst;
    } mem2wb_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem2ex_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the memory stage's pipeline buses and SRAM response.
// master: pipeline/SRAM side; slave: mem_stage.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [5:0]           stall;
    logic                 stallreq_mem;
    logic [EX2MEM_WD-1:0] ex2mem_bus;
    logic [31:0]          data_sram_rdata;
    logic                 data_sram_rvalid;
    logic [MEM2WB_WD-1:0] mem2wb_bus;
    logic [MEM2EX_WD-1:0] mem2ex_fwd;

    modport master (
        output stall,
        output ex2mem_bus,
        output data_sram_rdata,
        output data_sram_rvalid,
        input  stallreq_mem,
        input  mem2wb_bus,
        input  mem2ex_fwd
    );

    modport slave (
        input  stall,
        input  ex2mem_bus,
        input  data_sram_rdata,
        input  data_sram_rvalid,
        output stallreq_mem,
        output mem2wb_bus,
        output mem2ex_fwd
    );

endinterface

// File: rtl/mem_load_align.sv
// Load data aligner: picks byte/half lane by addr, then extends.
// In: lsu_op, addr[1:0], raw word. Out: data.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [5:0]  lsu_op,
    input  logic [1:0]  addr,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = raw[7:0];
        unique case (addr)
            2'd0: b = raw[7:0];
            2'd1: b = raw[15:8];
            2'd2: b = raw[23:16];
            2'd3: b = raw[31:24];
        endcase
        h = addr[1] ? raw[31:16] : raw[15:0];
        data = raw;
        unique case (1'b1)
            lsu_op[LSU_LB]:  data = {{24{b[7]}}, b};
            lsu_op[LSU_LBU]: data = {24'd0, b};
            lsu_op[LSU_LH]:  data = {{16{h[15]}}, h};
            lsu_op[LSU_LHU]: data = {16'd0, h};
            lsu_op[LSU_LW]:  data = raw;
            lsu_op[LSU_SW]:  data = raw;
            default:         data = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers EX->MEM bus, tracks the load response,
// buffers it while held, drives MEM->WB and MEM->EX forwarding.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    mem_stage_if.slave bus
);

    ex2mem_t    ex2mem_r;
    mem_state_e state_q;
    mem_state_e state_d;
    logic [31:0] rdata_buf;
    logic        buf_we;
    logic        hold;
    logic        bubble;
    logic        rvalid;
    logic        is_load;
    logic        stallreq;
    logic [31:0] raw;
    logic [31:0] aligned;
    logic [31:0] wdata;
    logic        we;
    mem2wb_t     wb;
    mem2ex_t     fwd;

    assign hold    = bus.stall[STALL_MEM];
    assign bubble  = hold & ~bus.stall[STALL_WB];
    assign rvalid  = bus.data_sram_rvalid;
    assign is_load = ex2mem_r.sel_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex2mem_r <= '0;
        end else if (bubble) begin
            ex2mem_r <= '0;
        end else if (!hold) begin
            ex2mem_r <= ex2mem_t'(bus.ex2mem_bus);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_buf <= '0;
        end else if (buf_we) begin
            rdata_buf <= bus.data_sram_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_load) begin
                    if (!rvalid) begin
                        state_d = WAIT;
                    end else if (hold) begin
                        state_d = HOLD;
                        buf_we  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (rvalid) begin
                    if (hold) begin
                        state_d = HOLD;
                        buf_we  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (!hold) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A bubble drops the instruction, so nothing is left to track.
        if (bubble) begin
            state_d = IDLE;
        end
    end

    assign stallreq = is_load & ~rvalid &
                      ((state_q == IDLE) | (state_q == WAIT));

    assign raw = (state_q == HOLD) ? rdata_buf : bus.data_sram_rdata;

    mem_load_align u_align (
        .lsu_op (ex2mem_r.lsu_op),
        .addr   (ex2mem_r.ex_result[1:0]),
        .raw    (raw),
        .data   (aligned)
    );

    assign wdata = is_load ? aligned : ex2mem_r.ex_result;
    assign we    = ex2mem_r.rf_we & ~stallreq;

    always_comb begin
        wb.rf_we     = we;
        wb.rf_waddr  = ex2mem_r.rf_waddr;
        wb.rf_wdata  = wdata;
        wb.pc        = ex2mem_r.pc;
        wb.inst      = ex2mem_r.inst;
        fwd.rf_we    = we;
        fwd.rf_waddr = ex2mem_r.rf_waddr;
        fwd.rf_wdata = wdata;
    end

    assign bus.stallreq_mem = stallreq;
    assign bus.mem2wb_bus   = wb;
    assign bus.mem2ex_fwd   = fwd;

    logic unused_bits;
    assign unused_bits = ^{ex2mem_r.data_ram_sel,
                           bus.stall[5], bus.stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios, then randomized traffic
// checked by a scoreboard against a behavioural load model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    mem_stage_if ifc();
    mem_stage dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    logic       ext_hold = 0;
    logic       force_en = 0;
    logic [5:0] force_val = 0;

    always_comb begin
        if (force_en) ifc.stall = force_val;
        else if (ifc.stallreq_mem | ext_hold) ifc.stall = 6'b011111;
        else ifc.stall = 6'b000000;
    end

    typedef struct {
        logic [101:0] wb;
        logic [37:0]  fwd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(int op, logic [31:0] a,
                                             logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (8 * a[1:0])) & 32'hFF;
        h = (d >> (16 * a[1])) & 32'hFFFF;
        case (op)
            0: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
            1: return b;
            2: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3: return h;
            default: return d;
        endcase
    endfunction

    // op: 0 lb,1 lbu,2 lh,3 lhu,4 lw,5 store,6 alu
    function automatic logic [112:0] mk(int op, logic [31:0] exr,
        logic we, logic [4:0] wa, logic [31:0] pc, logic [31:0] inst);
        logic [5:0] lsu;
        lsu = (op < 6) ? 6'(1 << op) : 6'd0;
        return {lsu, 4'hF, (op < 5), we, wa, exr, pc, inst};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // randomized stimulus state
    logic [112:0] cur;
    bit           cur_valid;
    int           cur_op;
    int           cur_lat;
    logic [31:0]  cur_rdata;
    exp_t         cur_exp;
    int           n = 0;
    bit           reg_load = 0;
    bit           done = 1;
    bit           prev_rv = 0;
    bit           will_cap;
    int           cnt = 0;
    logic [31:0]  reg_rdata = 0;

    task automatic gen(input bit en);
        logic [31:0] a, pc, inst, wd;
        logic        we;
        logic [4:0]  wa;
        if (en && $urandom_range(0, 4) != 0) begin
            cur_op = $urandom_range(0, 6);
            a = $urandom;
            pc = 32'h1000 + n * 4;
            n++;
            inst = $urandom;
            we = 1'($urandom);
            wa = 5'($urandom);
            cur_rdata = $urandom;
            cur_lat = $urandom_range(0, 3);
            wd = (cur_op < 5) ? ref_load(cur_op, a, cur_rdata) : a;
            cur = mk(cur_op, a, we, wa, pc, inst);
            cur_exp.wb = {we, wa, wd, pc, inst};
            cur_exp.fwd = {we, wa, wd};
            cur_valid = 1;
        end else begin
            cur = '0;
            cur_valid = 0;
        end
        ifc.ex2mem_bus = cur;
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (ifc.stallreq_mem) begin
                chk("wb_we_masked", ifc.mem2wb_bus[101], 1'b0);
                chk("fwd_we_masked", ifc.mem2ex_fwd[37], 1'b0);
            end
            if (ifc.mem2wb_bus[63:32] != 0 && !ifc.stall[3]) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL retire: got pc %h expected none",
                             ifc.mem2wb_bus[63:32]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("mem2wb", ifc.mem2wb_bus, e.wb);
                    chk("mem2ex", ifc.mem2ex_fwd, e.fwd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        ifc.ex2mem_bus = '0;
        ifc.data_sram_rdata = '0;
        ifc.data_sram_rvalid = 0;
        #1;
        chk("rst_wb", ifc.mem2wb_bus, 0);
        chk("rst_fwd", ifc.mem2ex_fwd, 0);
        chk("rst_req", ifc.stallreq_mem, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;

        // lw, response in entry cycle
        ifc.ex2mem_bus = mk(4, 32'h100, 1, 5'd5, 32'h40, 32'h1);
        tick;
        ifc.ex2mem_bus = '0;
        ifc.data_sram_rvalid = 1;
        ifc.data_sram_rdata = 32'h12345678;
        #1;
        chk("lw_req", ifc.stallreq_mem, 0);
        chk("lw_data", ifc.mem2wb_bus[95:64], 32'h12345678);
        chk("lw_we", ifc.mem2wb_bus[101], 1);
        chk("lw_state", dut.state_q, IDLE);
        tick;
        ifc.data_sram_rvalid = 0;
        #1;
        chk("lw_state2", dut.state_q, IDLE);

        // lb, response 3 cycles late
        ifc.ex2mem_bus = mk(0, 32'h103, 1, 5'd6, 32'h44, 32'h2);
        tick;
        ifc.ex2mem_bus = '0;
        ifc.data_sram_rdata = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lb_req", ifc.stallreq_mem, 1);
            chk("lb_we_mask", ifc.mem2wb_bus[101], 0);
            tick;
        end
        ifc.data_sram_rvalid = 1;
        ifc.data_sram_rdata = 32'h80FF00AA;
        #1;
        chk("lb_req_done", ifc.stallreq_mem, 0);
        chk("lb_data", ifc.mem2wb_bus[95:64], 32'hFFFFFF80);
        chk("lb_we", ifc.mem2wb_bus[101], 1);
        tick;
        ifc.data_sram_rvalid = 0;

        // lhu, response while held elsewhere
        ifc.ex2mem_bus = mk(3, 32'h102, 1, 5'd7, 32'h48, 32'h3);
        tick;
        ifc.ex2mem_bus = '0;
        ext_hold = 1;
        ifc.data_sram_rvalid = 1;
        ifc.data_sram_rdata = 32'hBEEF1234;
        tick;
        ifc.data_sram_rvalid = 0;
        ifc.data_sram_rdata = 0;
        #1;
        chk("lhu_state", dut.state_q, HOLD);
        chk("lhu_buf", dut.rdata_buf, 32'hBEEF1234);
        chk("lhu_req", ifc.stallreq_mem, 0);
        chk("lhu_hold_data", ifc.mem2wb_bus[95:64], 32'h0000BEEF);
        tick;
        ext_hold = 0;
        #1;
        chk("lhu_data", ifc.mem2wb_bus[95:64], 32'h0000BEEF);
        chk("lhu_we", ifc.mem2wb_bus[101], 1);
        tick;
        chk("lhu_state2", dut.state_q, IDLE);

        // external stall vector with load waiting
        ifc.ex2mem_bus = mk(4, 32'h200, 1, 5'd8, 32'h4C, 32'h4);
        tick;
        ifc.ex2mem_bus = '0;
        tick;
        chk("wait_state", dut.state_q, WAIT);
        force_en = 1;
        force_val = 6'b001111;
        tick;
        chk("bub_wb_we", ifc.mem2wb_bus[101], 0);
        chk("bub_fwd_we", ifc.mem2ex_fwd[37], 0);
        force_en = 0;

        // non-load with spurious response
        ifc.ex2mem_bus = mk(6, 32'h42, 1, 5'd9, 32'h50, 32'h5);
        tick;
        ifc.ex2mem_bus = '0;
        ifc.data_sram_rvalid = 1;
        ifc.data_sram_rdata = 32'hDEADBEEF;
        #1;
        chk("alu_data", ifc.mem2wb_bus[95:64], 32'h42);
        chk("alu_fwd", ifc.mem2ex_fwd[31:0], 32'h42);
        chk("alu_req", ifc.stallreq_mem, 0);
        tick;
        ifc.data_sram_rvalid = 0;
        #1;
        chk("alu_state", dut.state_q, IDLE);
        chk("alu_buf", dut.rdata_buf, 32'hBEEF1234);

        // async reset during WAIT
        ifc.ex2mem_bus = mk(4, 32'h300, 1, 5'd10, 32'h54, 32'h6);
        tick;
        ifc.ex2mem_bus = '0;
        tick;
        chk("pre_rst_state", dut.state_q, WAIT);
        chk("pre_rst_req", ifc.stallreq_mem, 1);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_req", ifc.stallreq_mem, 0);
        chk("mid_rst_wb", ifc.mem2wb_bus, 0);
        chk("mid_rst_fwd", ifc.mem2ex_fwd, 0);
        chk("mid_rst_state", dut.state_q, IDLE);
        chk("mid_rst_buf", dut.rdata_buf, 0);
        @(negedge clk) rst_n = 1;
        ifc.ex2mem_bus = mk(4, 32'h104, 1, 5'd11, 32'h58, 32'h7);
        tick;
        ifc.ex2mem_bus = '0;
        ifc.data_sram_rvalid = 1;
        ifc.data_sram_rdata = 32'hCAFEF00D;
        #1;
        chk("post_rst_data", ifc.mem2wb_bus[95:64], 32'hCAFEF00D);
        chk("post_rst_we", ifc.mem2wb_bus[101], 1);
        tick;
        ifc.data_sram_rvalid = 0;

        // randomized traffic
        mon_en = 1;
        gen(1);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            will_cap = !ifc.stall[3];
            if (will_cap && cur_valid) exp_q.push_back(cur_exp);
            @(posedge clk);
            #1;
            if (will_cap) begin
                reg_load = cur_valid && (cur_op < 5);
                cnt = cur_lat;
                done = 0;
                reg_rdata = cur_rdata;
                gen(i < 2900);
            end else if (reg_load && !done) begin
                if (prev_rv) done = 1;
                else cnt--;
            end
            ext_hold = ($urandom_range(0, 4) == 0);
            if (reg_load && !done && cnt == 0) begin
                ifc.data_sram_rvalid = 1;
                ifc.data_sram_rdata = reg_rdata;
                prev_rv = 1;
            end else begin
                prev_rv = 0;
                ifc.data_sram_rdata = $urandom;
                ifc.data_sram_rvalid = (!reg_load || done) &&
                                       ($urandom_range(0, 3) == 0);
            end
            #1;
            chk("stallreq", ifc.stallreq_mem,
                reg_load && !done && !ifc.data_sram_rvalid);
        end
        mon_en = 0;
        chk("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
